imul_dot_prod_accum: RTL and testbench

Downstream consumer of the fixed-latency integer multiplier's product stream. It accepts a vector length on a configuration handshake, then accumulates exactly that many 32-bit products arriving on a val/rdy port, and emits one 32-bit dot-product sum on a val/rdy output. It closes the loop between the multiplier's send interface and the memory/test sink that collects results.

---
 rtl/imul_dot_pkg.sv | 13 +
 rtl/imul_dot_prod_accum_if.sv | 30 +++
 rtl/imul_dot_prod_accum_dpath.sv | 85 ++++++++
 rtl/imul_dot_prod_accum.sv | 97 +++++++++
 tb/tb_imul_dot_prod_accum.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imul_dot_pkg.sv
// Shared types and constants for the dot-product accumulator that consumes
// the integer multiplier's product stream.
package imul_dot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int c_data_nbits = 32;

endpackage

// File: rtl/imul_dot_prod_accum_if.sv
// Bundle of the three val/rdy ports of the dot-product accumulator:
// length configuration, incoming products, and the outgoing sum.
interface imul_dot_prod_accum_if #(
  parameter int p_len_nbits = 8
);
  import imul_dot_pkg::*;

  logic                    cfg_val;
  logic                    cfg_rdy;
  logic [p_len_nbits-1:0]  cfg_msg;

  logic                    recv_val;
  logic                    recv_rdy;
  logic [c_data_nbits-1:0] recv_msg;

  logic                    send_val;
  logic                    send_rdy;
  logic [c_data_nbits-1:0] send_msg;

  modport master (
    output cfg_val, cfg_msg, recv_val, recv_msg, send_rdy,
    input  cfg_rdy, recv_rdy, send_val, send_msg
  );

  modport slave (
    input  cfg_val, cfg_msg, recv_val, recv_msg, send_rdy,
    output cfg_rdy, recv_rdy, send_val, send_msg
  );

endinterface

// File: rtl/imul_dot_prod_accum_dpath.sv
// Datapath of the dot-product accumulator: wrapping 32-bit accumulator with
// a clear mux, and the down-counter tracking how many products remain.
module imul_DotProdAccumDpath
  import imul_dot_pkg::*;
#(
  parameter int p_len_nbits = 8
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    acc_en,
  input  logic                    acc_clear,
  input  logic                    count_load,
  input  logic                    count_dec,
  input  logic [p_len_nbits-1:0]  cfg_msg,
  input  logic [c_data_nbits-1:0] recv_msg,
  output logic [c_data_nbits-1:0] acc,
  output logic                    count_is_one,
  output logic                    count_is_zero
);

  logic [c_data_nbits-1:0] sum;
  logic [c_data_nbits-1:0] acc_d;
  logic [p_len_nbits-1:0]  count_reg;

  vc_SimpleAdder #(.p_nbits(c_data_nbits)) acc_adder (
    .in0 (acc),
    .in1 (recv_msg),
    .out (sum)
  );

  // Clearing on a new length keeps a previous vector's sum out of the next one.
  assign acc_d = acc_clear ? '0 : sum;

  vc_EnReg #(.p_nbits(c_data_nbits)) acc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (acc_en),
    .d     (acc_d),
    .q     (acc)
  );

  always_ff @(posedge clk) begin
    if (reset)
      count_reg <= '0;
    else if (count_load)
      count_reg <= cfg_msg;
    else if (count_dec)
      count_reg <= count_reg - p_len_nbits'(1);
  end

  assign count_is_one  = (count_reg == p_len_nbits'(1));
  assign count_is_zero = (count_reg == '0);

endmodule

module vc_EnReg #(
  parameter int p_nbits = 1
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [p_nbits-1:0] d,
  output logic [p_nbits-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

module vc_SimpleAdder #(
  parameter int p_nbits = 1
)(
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  output logic [p_nbits-1:0] out
);

  assign out = in0 + in1;

endmodule

// File: rtl/imul_dot_prod_accum.sv
// Accepts a vector length, sums that many products from the multiplier and
// emits one 32-bit dot-product sum; control FSM lives here.
module imul_dot_prod_accum
  import imul_dot_pkg::*;
#(
  parameter int p_len_nbits = 8
)(
  input  logic                   clk,
  input  logic                   reset,
  imul_dot_prod_accum_if.slave   bus
);

  state_t state_reg;
  state_t state_next;

  logic cfg_rdy_c;
  logic recv_rdy_c;
  logic send_val_c;
  logic acc_en;
  logic acc_clear;
  logic count_load;
  logic count_dec;

  logic [c_data_nbits-1:0] acc;
  logic                    count_is_one;
  logic                    count_is_zero;

  imul_DotProdAccumDpath #(.p_len_nbits(p_len_nbits)) dpath (
    .clk           (clk),
    .reset         (reset),
    .acc_en        (acc_en),
    .acc_clear     (acc_clear),
    .count_load    (count_load),
    .count_dec     (count_dec),
    .cfg_msg       (bus.cfg_msg),
    .recv_msg      (bus.recv_msg),
    .acc           (acc),
    .count_is_one  (count_is_one),
    .count_is_zero (count_is_zero)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Ready/valid come only from state_reg, so no val input reaches a rdy output.
  always_comb begin
    state_next = state_reg;
    cfg_rdy_c  = 1'b0;
    recv_rdy_c = 1'b0;
    send_val_c = 1'b0;
    acc_en     = 1'b0;
    acc_clear  = 1'b0;
    count_load = 1'b0;
    count_dec  = 1'b0;

    case (state_reg)
      IDLE: begin
        cfg_rdy_c = 1'b1;
        if (bus.cfg_val) begin
          acc_en     = 1'b1;
          acc_clear  = 1'b1;
          count_load = 1'b1;
          state_next = (bus.cfg_msg == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        recv_rdy_c = 1'b1;
        if (count_is_zero) begin
          state_next = DONE;
        end else if (bus.recv_val) begin
          acc_en    = 1'b1;
          count_dec = 1'b1;
          if (count_is_one)
            state_next = DONE;
        end
      end
      DONE: begin
        send_val_c = 1'b1;
        if (bus.send_rdy)
          state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.cfg_rdy  = cfg_rdy_c  & ~reset;
  assign bus.recv_rdy = recv_rdy_c & ~reset;
  assign bus.send_val = send_val_c & ~reset;
  assign bus.send_msg = bus.send_val ? acc : '0;

endmodule

// File: tb/tb_imul_dot_prod_accum.sv
// Self-checking bench for imul_dot_prod_accum: fixed vector table, cycle-exact
// corner sequences, and random product streams against a summing model.
module tb_imul_dot_prod_accum;
  import imul_dot_pkg::*;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  imul_dot_prod_accum_if #(.p_len_nbits(8)) bus ();

  imul_dot_prod_accum #(.p_len_nbits(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned len;
    logic [31:0] prod [4];
    logic [31:0] expect_sum;
    int unsigned bubble_pct;
    int unsigned stall_pct;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_vec(input int i, input int unsigned len,
                         input logic [31:0] p0, input logic [31:0] p1,
                         input logic [31:0] p2, input logic [31:0] p3,
                         input logic [31:0] exp_sum,
                         input int unsigned bub, input int unsigned stall);
    tbl[i].len        = len;
    tbl[i].prod[0]    = p0;
    tbl[i].prod[1]    = p1;
    tbl[i].prod[2]    = p2;
    tbl[i].prod[3]    = p3;
    tbl[i].expect_sum = exp_sum;
    tbl[i].bubble_pct = bub;
    tbl[i].stall_pct  = stall;
  endtask

  // Drive one whole vector with random bubbles/stalls, checking the protocol
  // every cycle; called and returned at a falling edge.
  task automatic run_vector(input int unsigned n, input logic [31:0] prods[$],
                            input int unsigned bubble_pct, input int unsigned stall_pct,
                            output logic [31:0] got);
    int unsigned idx;
    int          cyc;
    bit          have_prev;
    bit          finished;
    logic [31:0] prev;
    idx = 0; cyc = 0; have_prev = 0; finished = 0; prev = '0; got = '0;
    bus.cfg_val  = 1'b1;
    bus.cfg_msg  = n[7:0];
    bus.recv_val = 1'b0;
    bus.send_rdy = 1'b0;
    #1;
    while (!bus.cfg_rdy && cyc < 100) begin
      tick();
      cyc++;
    end
    if (!bus.cfg_rdy) begin
      check("cfg_accept_timeout", 32'(bus.cfg_rdy), 32'd1);
      bus.cfg_val = 1'b0;
      return;
    end
    tick();
    bus.cfg_val = 1'b0;
    bus.cfg_msg = 8'($urandom());
    cyc = 0;
    while (!finished && cyc < 3000) begin
      bus.recv_val = (idx < n) && ($urandom_range(0, 99) >= bubble_pct);
      bus.recv_msg = (idx < n) ? prods[idx] : $urandom();
      bus.send_rdy = ($urandom_range(0, 99) >= stall_pct);
      #1;
      if (bus.recv_rdy && idx >= n)
        check("recv_rdy_after_last", 32'(bus.recv_rdy), 32'd0);
      if (bus.send_val) begin
        if (have_prev)
          check("send_msg_stable", bus.send_msg, prev);
        else
          check("products_before_sum", idx, n);
        prev      = bus.send_msg;
        have_prev = 1'b1;
        if (bus.send_rdy) begin
          got      = bus.send_msg;
          finished = 1'b1;
        end
      end else begin
        check("send_msg_zero_idle", bus.send_msg, 32'd0);
      end
      if (bus.recv_val && bus.recv_rdy)
        idx++;
      tick();
      cyc++;
    end
    if (!finished)
      check("sum_timeout", 32'(finished), 32'd1);
    bus.recv_val = 1'b0;
    bus.send_rdy = 1'b0;
  endtask

  task automatic applyStimulus();
    logic [31:0] q [$];
    logic [31:0] got;
    logic [31:0] ref_sum;
    int unsigned n;
    logic [31:0] a;
    logic [31:0] b;
    int unsigned k;

    // Reset: every val/rdy output low while reset is held.
    reset = 1'b1;
    bus.cfg_val = 1'b0; bus.cfg_msg = '0;
    bus.recv_val = 1'b0; bus.recv_msg = '0;
    bus.send_rdy = 1'b0;
    @(negedge clk);
    check("reset_cfg_rdy", 32'(bus.cfg_rdy), 32'd0);
    check("reset_send_val", 32'(bus.send_val), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("idle_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    check("idle_recv_rdy", 32'(bus.recv_rdy), 32'd0);
    check("idle_send_msg", bus.send_msg, 32'd0);

    // Cycle-exact basic vector: N=3, products 2,3,4 back-to-back.
    bus.cfg_val = 1'b1; bus.cfg_msg = 8'd3;
    tick();
    bus.cfg_val = 1'b0;
    bus.recv_val = 1'b1; bus.recv_msg = 32'd2; #1;
    check("basic_c1_recv_rdy", 32'(bus.recv_rdy), 32'd1);
    check("basic_c1_cfg_rdy", 32'(bus.cfg_rdy), 32'd0);
    tick(); bus.recv_msg = 32'd3;
    tick(); bus.recv_msg = 32'd4; #1;
    check("basic_c3_send_val", 32'(bus.send_val), 32'd0);
    tick(); bus.recv_val = 1'b0; bus.send_rdy = 1'b1; #1;
    check("basic_c4_send_val", 32'(bus.send_val), 32'd1);
    check("basic_c4_send_msg", bus.send_msg, 32'd9);
    check("basic_c4_recv_rdy", 32'(bus.recv_rdy), 32'd0);
    tick(); bus.send_rdy = 1'b0; #1;
    check("basic_c5_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    check("basic_c5_send_val", 32'(bus.send_val), 32'd0);

    // Zero length: sum of zero appears the very next cycle.
    bus.recv_val = 1'b1; bus.recv_msg = 32'hDEAD_BEEF;
    bus.cfg_val = 1'b1; bus.cfg_msg = 8'd0;
    tick();
    bus.cfg_val = 1'b0; #1;
    check("zero_c1_send_val", 32'(bus.send_val), 32'd1);
    check("zero_c1_send_msg", bus.send_msg, 32'd0);
    check("zero_c1_recv_rdy", 32'(bus.recv_rdy), 32'd0);
    bus.send_rdy = 1'b1;
    tick();
    bus.send_rdy = 1'b0; bus.recv_val = 1'b0;

    // Bubbles every other cycle, then 5 stalled cycles in DONE.
    bus.cfg_val = 1'b1; bus.cfg_msg = 8'd4;
    tick();
    bus.cfg_val = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      bus.recv_val = (c % 2 == 0);
      bus.recv_msg = bus.recv_val ? 32'(k + 1) : 32'hFFFF_0000;
      #1;
      if (bus.recv_val && bus.recv_rdy) k++;
      tick();
    end
    check("bp_products_taken", k, 32'd4);
    bus.recv_val = 1'b1; bus.recv_msg = 32'd100;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_hold_send_val", 32'(bus.send_val), 32'd1);
      check("bp_hold_send_msg", bus.send_msg, 32'd10);
      check("bp_hold_recv_rdy", 32'(bus.recv_rdy), 32'd0);
      tick();
    end
    bus.send_rdy = 1'b1; #1;
    check("bp_release_send_msg", bus.send_msg, 32'd10);
    tick();
    bus.send_rdy = 1'b0; bus.recv_val = 1'b0; #1;
    check("bp_single_send", 32'(bus.send_val), 32'd0);
    check("bp_back_idle", 32'(bus.cfg_rdy), 32'd1);

    // Reset mid-vector discards the partial sum.
    bus.cfg_val = 1'b1; bus.cfg_msg = 8'd5;
    tick();
    bus.cfg_val = 1'b0;
    bus.recv_val = 1'b1; bus.recv_msg = 32'd10;
    tick(); bus.recv_msg = 32'd20;
    tick(); bus.recv_val = 1'b0;
    reset = 1'b1; #1;
    check("rst_mid_cfg_rdy", 32'(bus.cfg_rdy), 32'd0);
    check("rst_mid_recv_rdy", 32'(bus.recv_rdy), 32'd0);
    check("rst_mid_send_val", 32'(bus.send_val), 32'd0);
    tick();
    reset = 1'b0; #1;
    check("rst_after_cfg_rdy", 32'(bus.cfg_rdy), 32'd1);
    q = {}; q.push_back(32'd7);
    run_vector(1, q, 0, 0, got);
    check("rst_then_n1_sum", got, 32'd7);

    // Fixed table with hand-computed sums.
    set_vec(0, 3, 32'd2, 32'd3, 32'd4, 32'd0, 32'd9, 0, 0);
    set_vec(1, 2, 32'hFFFF_FFFF, 32'h0000_0003, 32'd0, 32'd0, 32'h0000_0002, 0, 30);
    set_vec(2, 2, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'h0000_0000, 40, 0);
    set_vec(3, 4, 32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 50, 50);
    set_vec(4, 4, 32'd10, 32'd20, 32'd30, 32'd40, 32'd100, 20, 60);
    set_vec(5, 3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd2, 10, 10);
    for (int i = 0; i < 6; i++) begin
      q = {};
      for (int j = 0; j < int'(tbl[i].len); j++) q.push_back(tbl[i].prod[j]);
      run_vector(tbl[i].len, q, tbl[i].bubble_pct, tbl[i].stall_pct, got);
      check($sformatf("table_%0d_sum", i), got, tbl[i].expect_sum);
    end

    // Random multiplier-fed vectors: model is the wrapped sum of a*b.
    for (int v = 0; v < 24; v++) begin
      n = (v < 2) ? 0 : $urandom_range(1, 255);
      q = {};
      ref_sum = '0;
      for (int j = 0; j < int'(n); j++) begin
        a = $urandom();
        b = $urandom();
        q.push_back(a * b);
        ref_sum = ref_sum + a * b;
      end
      run_vector(n, q, $urandom_range(0, 60), $urandom_range(0, 60), got);
      check($sformatf("random_%0d_sum_len%0d", v, n), got, ref_sum);
    end
  endtask

  task automatic checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    applyStimulus();
    checkOutput();
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
